reg_bus_master: RTL

- Register-bus initiator. Turns the UART receive byte stream into single-cycle writes on the shared register bus (`register_addr` / `register_data` / `register_rdy`).
- Consumed by every `fully_associative_register` and `adc_block` in the design.
- Sits between the UART receiver and all channel/trigger configuration registers.
- Frame format: one address byte, then ceil(REG_DATA_WIDTH/8) data bytes, MSB first.
- An inter-byte timeout resynchronises on lost bytes.

---
 rtl/reg_bus_master_pkg.sv | 23 ++
 rtl/reg_bus_master.sv | 120 ++++++++++++
 2 files changed

// File: rtl/reg_bus_master_pkg.sv
// Shared constants for the register-bus initiator: default widths, timeout and the register address map.
package reg_bus_master_pkg;

   localparam int DEF_ADDR_WIDTH        = 8;
   localparam int DEF_DATA_WIDTH        = 16;
   localparam int DEF_RX_WIDTH          = 8;
   localparam int DEF_RX_TIMEOUT_CYCLES = 100000;

   // Configuration register address map
   localparam logic [7:0] ADDR_ADC_CFG      = 8'h03;
   localparam logic [7:0] ADDR_TRIG_LEVEL   = 8'h05;
   localparam logic [7:0] ADDR_TRIG_MODE    = 8'h06;
   localparam logic [7:0] ADDR_TRIG_HOLDOFF = 8'h07;
   localparam logic [7:0] ADDR_CH_ENABLE    = 8'h08;
   localparam logic [7:0] ADDR_CH_GAIN      = 8'h09;
   localparam logic [7:0] ADDR_CH_OFFSET    = 8'h0A;
   localparam logic [7:0] ADDR_CH_DELAY     = 8'h0B;

   function automatic int n_data_bytes(input int data_width);
      return (data_width + 7) / 8;
   endfunction

endpackage

// File: rtl/reg_bus_master.sv
// Turns UART bytes (address byte, then MSB-first data bytes) into one-cycle register-bus writes.
// Output strobe one cycle after the last data byte; an inter-byte timeout drops partial frames.
module reg_bus_master
   import reg_bus_master_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int REG_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RX_DATA_WIDTH  = DEF_RX_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_RX_TIMEOUT_CYCLES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [RX_DATA_WIDTH-1:0]  rx_data,
   input  logic                      rx_rdy,
   output logic [REG_ADDR_WIDTH-1:0] register_addr,
   output logic [REG_DATA_WIDTH-1:0] register_data,
   output logic                      register_rdy,
   output logic                      frame_err
);

   localparam int N_DATA_BYTES = n_data_bytes(REG_DATA_WIDTH);
   localparam int CNT_W        = 3;
   localparam int TO_W         = $clog2(TIMEOUT_CYCLES);

   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_DATA_BYTES - 1);
   // Expiry is flagged on the edge where the counter would reach TIMEOUT_CYCLES-1
   localparam logic [TO_W-1:0]  TO_EXPIRE = TO_W'(TIMEOUT_CYCLES - 2);
   localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      S_ADDR = 1'b0,
      S_DATA = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          byte_cnt_q, byte_cnt_d;
   logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
   logic [REG_ADDR_WIDTH-1:0] shadow_addr_q, shadow_addr_d;
   logic [REG_DATA_WIDTH-1:0] shadow_data_q, shadow_data_d;
   logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
   logic [REG_DATA_WIDTH-1:0] reg_data_q, reg_data_d;
   logic                      reg_rdy_q, reg_rdy_d;
   logic                      frame_err_q, frame_err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_ADDR;
         byte_cnt_q    <= '0;
         to_cnt_q      <= '0;
         shadow_addr_q <= '0;
         shadow_data_q <= '0;
         reg_addr_q    <= '0;
         reg_data_q    <= '0;
         reg_rdy_q     <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         to_cnt_q      <= to_cnt_d;
         shadow_addr_q <= shadow_addr_d;
         shadow_data_q <= shadow_data_d;
         reg_addr_q    <= reg_addr_d;
         reg_data_q    <= reg_data_d;
         reg_rdy_q     <= reg_rdy_d;
         frame_err_q   <= frame_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      to_cnt_d      = to_cnt_q;
      shadow_addr_d = shadow_addr_q;
      shadow_data_d = shadow_data_q;
      reg_addr_d    = reg_addr_q;
      reg_data_d    = reg_data_q;
      reg_rdy_d     = 1'b0;
      frame_err_d   = 1'b0;
      case (state_q)
         S_ADDR: begin
            to_cnt_d = '0;
            if (rx_rdy) begin
               shadow_addr_d = rx_data[REG_ADDR_WIDTH-1:0];
               byte_cnt_d    = '0;
               state_d       = S_DATA;
            end
         end
         S_DATA: begin
            if (rx_rdy) begin
               // Shift in MSB first; bits beyond REG_DATA_WIDTH fall off the top
               shadow_data_d = (shadow_data_q << RX_DATA_WIDTH) | REG_DATA_WIDTH'(rx_data);
               to_cnt_d      = '0;
               if (byte_cnt_q == LAST_BYTE) begin
                  reg_addr_d = shadow_addr_q;
                  reg_data_d = shadow_data_d;
                  reg_rdy_d  = 1'b1;
                  byte_cnt_d = '0;
                  state_d    = S_ADDR;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end else if (to_cnt_q == TO_EXPIRE) begin
               frame_err_d = 1'b1;
               to_cnt_d    = '0;
               byte_cnt_d  = '0;
               state_d     = S_ADDR;
            end else if (to_cnt_q != TO_MAX) begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         default: state_d = S_ADDR;
      endcase
   end

   assign register_addr = reg_addr_q;
   assign register_data = reg_data_q;
   assign register_rdy  = reg_rdy_q;
   assign frame_err     = frame_err_q;

endmodule
